// File: rtl/apb_master_port.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_port
// Function : single-outstanding APB3 initiator with req/gnt front end,
//            registered response strobe and PREADY timeout abort.
// Revision : 1.0
// ============================================================================
module apb_master_port #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT        = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]                state_q,  state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q,  paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [31:0]               rdata_q,  rdata_d;
  logic                      err_q,    err_d;
  logic                      rvalid_q, rvalid_d;
  logic [CNT_W-1:0]          cnt_q,    cnt_d;

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rvalid_d = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          paddr_d  = addr_i;
          pwdata_d = wdata_i;
          pwrite_d = we_i;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // A ready slave beats a timeout firing in the same cycle.
        if (PREADY) begin
          rvalid_d = 1'b1;
          err_d    = PSLVERR;
          rdata_d  = pwrite_q ? 32'h0 : PRDATA;
          state_d  = S_IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = 32'h0;
          state_d  = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register so reset drops PSEL/PENABLE at once
  always_comb begin
    gnt_o   = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      S_IDLE:   gnt_o = req_i;
      S_SETUP: begin
        PSEL   = 1'b1;
        busy_o = 1'b1;
      end
      S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        busy_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign rvalid_o = rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_port
// Function : self-checking bench for apb_master_port (TIMEOUT = 8).
// Revision : 1.0
// ============================================================================
module tb_apb_master_port;

  localparam int AW = 12;
  localparam int TO = 8;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic          req_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic          we_i = 1'b0;
  logic [31:0]   wdata_i = '0;
  logic          gnt_o, rvalid_o, err_o, busy_o;
  logic [31:0]   rdata_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE, PSEL, PENABLE;
  logic [31:0]   PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_master_port #(.APB_ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .busy_o(busy_o), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  // Runs one transfer against a slave that answers after 'waits' low-PREADY
  // ACCESS cycles. Cycle 0 is the request cycle; observations are returned.
  task automatic run_xfer(input logic [AW-1:0] a, input logic w, input logic [31:0] wd,
                          input int waits, input logic [31:0] prd, input logic serr,
                          output int gnt_seen, output int resp_cyc, output logic [31:0] rd,
                          output logic e, output int sel_n, output int en_n,
                          output int busy_n, output int unstable);
    int acc;
    @(posedge HCLK); #1;
    req_i = 1'b1; addr_i = a; we_i = w; wdata_i = wd; PREADY = 1'b0;
    #1;
    gnt_seen = int'(gnt_o);
    resp_cyc = -1; rd = '0; e = 1'b0;
    sel_n = 0; en_n = 0; busy_n = 0; unstable = 0; acc = 0;
    for (int c = 1; c <= 40 && resp_cyc < 0; c++) begin
      @(posedge HCLK); #1;
      req_i = 1'b0; addr_i = AW'($urandom); wdata_i = $urandom; we_i = 1'($urandom);
      if (PSEL && PENABLE) begin
        PREADY = (acc == waits);
        acc++;
      end else begin
        PREADY = 1'b0;
      end
      PRDATA  = PREADY ? prd : $urandom;
      PSLVERR = PREADY ? serr : 1'($urandom);
      #1;
      if (PSEL) begin
        sel_n++;
        if (PADDR !== a || PWRITE !== w || PWDATA !== wd) unstable++;
      end
      if (PENABLE) en_n++;
      if (busy_o) busy_n++;
      if (rvalid_o) begin
        resp_cyc = c; rd = rdata_o; e = err_o;
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  task automatic test_reset;
    HRESET = 1'b1; req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #2;
      checks++;
      if ({gnt_o, rvalid_o, rdata_o, err_o, busy_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got rdata=%h paddr=%h psel=%b busy=%b expected all zero",
                 i, rdata_o, PADDR, PSEL, busy_o);
      end
    end
    @(posedge HCLK); #1; HRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #2;
      checks++;
      if ({gnt_o, rvalid_o, busy_o, PSEL, PENABLE, PADDR, PWDATA} !== '0) begin
        errors++;
        $display("FAIL idle_after_reset got gnt=%b rvalid=%b busy=%b psel=%b expected 0", gnt_o, rvalid_o, busy_o, PSEL);
      end
    end
  endtask

  task automatic test_zero_wait_read;
    int g, rc, s, en, b, u; logic [31:0] rd; logic e;
    run_xfer(12'h004, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, g, rc, rd, e, s, en, b, u);
    checks++; if (g !== 1) begin errors++; $display("FAIL zw_gnt got %0d expected 1", g); end
    checks++; if (rc !== 3) begin errors++; $display("FAIL zw_resp_cycle got %0d expected 3", rc); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++; $display("FAIL zw_rdata got %h err %b expected deadbeef err 0", rd, e); end
    checks++; if (s !== 2 || en !== 1 || b !== 2 || u !== 0) begin
      errors++; $display("FAIL zw_bus got sel=%0d en=%0d busy=%0d unstable=%0d expected 2 1 2 0", s, en, b, u); end
  endtask

  task automatic test_wait_write_err;
    int g, rc, s, en, b, u; logic [31:0] rd; logic e;
    run_xfer(12'h010, 1'b1, 32'h5, 4, 32'hCAFE0000, 1'b1, g, rc, rd, e, s, en, b, u);
    checks++; if (rc !== 7) begin errors++; $display("FAIL ww_resp_cycle got %0d expected 7", rc); end
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL ww_resp got rdata %h err %b expected 0 err 1", rd, e); end
    checks++; if (u !== 0 || en !== 5) begin
      errors++; $display("FAIL ww_pwdata_stable got unstable=%0d en=%0d expected 0 5", u, en); end
  endtask

  task automatic test_timeout;
    int g, rc, s, en, b, u; logic [31:0] rd; logic e;
    run_xfer(12'h020, 1'b0, 32'h0, 1000, 32'h12345678, 1'b0, g, rc, rd, e, s, en, b, u);
    checks++; if (en !== TO || rc !== TO + 2) begin
      errors++; $display("FAIL to_access_cycles got en=%0d resp=%0d expected %0d %0d", en, rc, TO, TO + 2); end
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL to_resp got rdata %h err %b expected 0 err 1", rd, e); end
    @(posedge HCLK); #2;
    checks++; if (PSEL !== 1'b0 || rvalid_o !== 1'b0) begin
      errors++; $display("FAIL to_after got psel=%b rvalid=%b expected 0 0", PSEL, rvalid_o); end
    // Slave answers on the last ACCESS cycle the timeout allows.
    run_xfer(12'h024, 1'b0, 32'h0, TO - 1, 32'hA5A5_0F0F, 1'b0, g, rc, rd, e, s, en, b, u);
    checks++; if (rc !== TO + 2 || rd !== 32'hA5A5_0F0F || e !== 1'b0) begin
      errors++; $display("FAIL to_boundary got resp=%0d rdata=%h err=%b expected %0d a5a50f0f 0", rc, rd, e, TO + 2); end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] addrs [3];
    logic [31:0]   dat [3];
    int gcyc [3];
    int rcyc [3];
    logic [31:0] rdat [3];
    int ng, nr, nacc, extra;
    for (int i = 0; i < 3; i++) begin
      addrs[i] = AW'($urandom); dat[i] = $urandom; gcyc[i] = -1; rcyc[i] = -1; rdat[i] = '0;
    end
    ng = 0; nr = 0; nacc = 0; extra = 0;
    @(posedge HCLK); #1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(posedge HCLK); #1; end
      req_i = (ng < 3); we_i = 1'b0; addr_i = addrs[(ng < 3) ? ng : 2];
      if (PSEL && PENABLE) begin
        PREADY = 1'b1; PRDATA = dat[(nacc < 3) ? nacc : 2]; PSLVERR = 1'b0; nacc++;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom;
      end
      #1;
      if (gnt_o) begin if (ng < 3) gcyc[ng] = c; else extra++; ng++; end
      if (rvalid_o) begin
        if (nr < 3) begin rcyc[nr] = c; rdat[nr] = rdata_o; end else extra++;
        nr++;
      end
    end
    req_i = 1'b0; PREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gcyc[i] !== 3 * i || rcyc[i] !== 3 * i + 3 || rdat[i] !== dat[i]) begin
        errors++;
        $display("FAIL b2b_%0d got gnt@%0d rvalid@%0d data %h expected %0d %0d %h",
                 i, gcyc[i], rcyc[i], rdat[i], 3 * i, 3 * i + 3, dat[i]);
      end
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid_access;
    int rv, g, rc, s, en, b, u; logic [31:0] rd; logic e;
    rv = 0;
    @(posedge HCLK); #1; req_i = 1'b1; addr_i = 12'h0AB; we_i = 1'b0; PREADY = 1'b0;
    @(posedge HCLK); #1; req_i = 1'b0;
    @(posedge HCLK); #1;
    checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL rst_pre_penable got %b expected 1", PENABLE); end
    #2; HRESET = 1'b1; #1;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_async_drop got psel=%b penable=%b expected 0 0", PSEL, PENABLE); end
    for (int i = 0; i < 2; i++) begin @(posedge HCLK); #2; if (rvalid_o) rv++; end
    #1; HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge HCLK); #2; if (rvalid_o) rv++; end
    checks++; if (rv !== 0) begin errors++; $display("FAIL rst_no_rvalid got %0d strobes expected 0", rv); end
    run_xfer(12'h0C0, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b0, g, rc, rd, e, s, en, b, u);
    checks++; if (rc !== 4 || rd !== 32'h0BAD_F00D || e !== 1'b0) begin
      errors++; $display("FAIL rst_recover got resp=%0d rdata=%h err=%b expected 4 0badf00d 0", rc, rd, e); end
  endtask

  // Reference: a transfer lasts 3 + waits cycles, or aborts after TO ACCESS cycles.
  task automatic test_random;
    int g, rc, s, en, b, u, waits, exp_rc;
    logic [31:0] rd, prd, wd, exp_rd;
    logic e, exp_e, w, serr;
    logic [AW-1:0] a;
    for (int n = 0; n < 20; n++) begin
      a = AW'($urandom); w = 1'($urandom); wd = $urandom; prd = $urandom;
      serr = ($urandom_range(0, 3) == 0); waits = $urandom_range(0, TO + 3);
      if (waits >= TO) begin
        exp_rc = TO + 2; exp_e = 1'b1; exp_rd = 32'h0;
      end else begin
        exp_rc = 3 + waits; exp_e = serr; exp_rd = w ? 32'h0 : prd;
      end
      run_xfer(a, w, wd, waits, prd, serr, g, rc, rd, e, s, en, b, u);
      checks++;
      if (g !== 1 || rc !== exp_rc || rd !== exp_rd || e !== exp_e) begin
        errors++;
        $display("FAIL rand_%0d got gnt=%0d resp=%0d rdata=%h err=%b expected 1 %0d %h %b",
                 n, g, rc, rd, e, exp_rc, exp_rd, exp_e);
      end
      checks++;
      if (s !== exp_rc - 1 || en !== exp_rc - 2 || b !== exp_rc - 1 || u !== 0) begin
        errors++;
        $display("FAIL rand_bus_%0d got sel=%0d en=%0d busy=%0d unstable=%0d expected %0d %0d %0d 0",
                 n, s, en, b, u, exp_rc - 1, exp_rc - 2, exp_rc - 1);
      end
      @(posedge HCLK); #2;
      checks++;
      if (rvalid_o !== 1'b0 || rdata_o !== exp_rd || err_o !== exp_e) begin
        errors++;
        $display("FAIL rand_hold_%0d got rvalid=%b rdata=%h err=%b expected 0 %h %b",
                 n, rvalid_o, rdata_o, err_o, exp_rd, exp_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
